// File: rtl/bus_arbiter_pkg.sv
// Package: bus_arbiter_pkg
// Shared types for the two-master bus arbiter.
//   master_id_t : identifies a bus master (0 = instruction fetch, 1 = load/store)
//   bus_req_t   : one master's request bundle as seen by the arbiter mux
package bus_arbiter_pkg;

    typedef logic master_id_t;

    localparam int         NUM_MASTERS  = 2;
    localparam master_id_t MASTER_FETCH = 1'b0;
    localparam master_id_t MASTER_DATA  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] write_data;
        logic [3:0]  byte_enable;
        logic        write_req;
        logic        read_req;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter_read_tag_fifo.sv
// Module: read_tag_fifo
// Synchronous FIFO of master IDs. One entry is pushed for every read the
// arbiter issues and popped for every downstream response, so the head always
// names the master that owns the next in-order response.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (clears all entries)
//   push, push_id     enqueue push_id (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   full, empty       occupancy flags
//   head              ID at the front of the queue (valid when !empty)
module read_tag_fifo
    import bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    master_id_t       mem_q [DEPTH];
    master_id_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MASTER_FETCH;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Module: bus_arbiter
// Shares one system-bus port between the instruction-fetch master (m0) and the
// load/store master (m1). Round-robin grant, read tagging, and in-order
// response routing back to the issuing master.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   mN_addr/write_data/byte_enable  request fields from master N
//   mN_write_req, mN_read_req       request strobes, held until mN_ready
//   mN_ready                        request from master N accepted this cycle
//   mN_read_data                    downstream read data (broadcast)
//   mN_read_data_valid              response belongs to a read issued by mN
//   bus_ready                       downstream can accept a request
//   bus_addr/write_data/byte_enable granted master's fields, 0 when idle
//   bus_write_req, bus_read_req     granted master's strobes, 0 when idle
//   bus_read_data(_valid)           downstream in-order read response
//   resp_error                      1-cycle pulse: response arrived with no tag
//
// Handshake: a request transfers on a cycle where the master drives a
// request strobe and its mN_ready is high. mN_ready depends on the
// request strobes, bus_ready and registered state only; it never depends on
// bus_read_data_valid, so a response popping a full tag FIFO frees room for
// a read only from the following cycle.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_write_req,
    input  logic        m0_read_req,
    output logic [31:0] m0_read_data,
    output logic        m0_read_data_valid,

    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_write_req,
    input  logic        m1_read_req,
    output logic [31:0] m1_read_data,
    output logic        m1_read_data_valid,

    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_write_req,
    output logic        bus_read_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid,

    output logic        resp_error
);

    bus_req_t                req [NUM_MASTERS];
    bus_req_t                granted;
    logic [NUM_MASTERS-1:0]  eligible;
    logic                    grant_valid;
    master_id_t              grant_id;
    logic                    accept;

    master_id_t              last_grant_q, last_grant_d;
    logic                    resp_error_q, resp_error_d;

    logic                    tag_push, tag_pop;
    logic                    tag_full, tag_empty;
    master_id_t              tag_head;

    // A read (including a combined write+read, which is tagged as a read)
    // needs a free tag slot; a pure write is always eligible.
    always_comb begin
        req[0] = '{addr: m0_addr, write_data: m0_write_data,
                   byte_enable: m0_byte_enable,
                   write_req: m0_write_req, read_req: m0_read_req};
        req[1] = '{addr: m1_addr, write_data: m1_write_data,
                   byte_enable: m1_byte_enable,
                   write_req: m1_write_req, read_req: m1_read_req};
        for (int n = 0; n < NUM_MASTERS; n++) begin
            eligible[n] = (req[n].write_req | req[n].read_req)
                        & (~req[n].read_req | ~tag_full);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = MASTER_FETCH;
        case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = MASTER_FETCH;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = MASTER_DATA;
            end
            2'b11: begin
                // Contention: the master that did not win last time goes.
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = MASTER_FETCH;
            end
        endcase

        granted      = grant_valid ? req[grant_id] : '0;
        accept       = grant_valid & bus_ready;
        last_grant_d = accept ? grant_id : last_grant_q;
        tag_push     = accept & granted.read_req;
        tag_pop      = bus_read_data_valid & ~tag_empty;
        resp_error_d = bus_read_data_valid & tag_empty;
    end

    assign bus_addr        = granted.addr;
    assign bus_write_data  = granted.write_data;
    assign bus_byte_enable = granted.byte_enable;
    assign bus_write_req   = granted.write_req;
    assign bus_read_req    = granted.read_req;

    assign m0_ready = accept & (grant_id == MASTER_FETCH);
    assign m1_ready = accept & (grant_id == MASTER_DATA);

    assign m0_read_data       = bus_read_data;
    assign m1_read_data       = bus_read_data;
    assign m0_read_data_valid = tag_pop & (tag_head == MASTER_FETCH);
    assign m1_read_data_valid = tag_pop & (tag_head == MASTER_DATA);

    assign resp_error = resp_error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= MASTER_DATA;
            resp_error_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_error_q <= resp_error_d;
        end
    end

    read_tag_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tag_push),
        .push_id (grant_id),
        .pop     (tag_pop),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (tag_head)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int MAX = 4;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_data_valid, m1_read_data_valid;
  logic        bus_ready;
  logic [31:0] bus_addr, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_write_req, bus_read_req;
  logic [31:0] bus_read_data;
  logic        bus_read_data_valid;
  logic        resp_error;

  bus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_byte_enable(m0_byte_enable), .m0_write_req(m0_write_req),
    .m0_read_req(m0_read_req), .m0_read_data(m0_read_data),
    .m0_read_data_valid(m0_read_data_valid),
    .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_byte_enable(m1_byte_enable), .m1_write_req(m1_write_req),
    .m1_read_req(m1_read_req), .m1_read_data(m1_read_data),
    .m1_read_data_valid(m1_read_data_valid),
    .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_write_req(bus_write_req),
    .bus_read_req(bus_read_req), .bus_read_data(bus_read_data),
    .bus_read_data_valid(bus_read_data_valid), .resp_error(resp_error)
  );

  // ---------------- scoreboard / counters ----------------
  int errors = 0;
  int checks = 0;

  // reference model: queue of issuing master IDs for reads in flight
  int exp_q[$];
  int model_last = 1;
  logic model_rerr = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // who should win this cycle by the round-robin rules; -1 = nobody
  function automatic int model_winner();
    bit c0, c1;
    c0 = (m0_write_req || m0_read_req) && (!m0_read_req || exp_q.size() < MAX);
    c1 = (m1_write_req || m1_read_req) && (!m1_read_req || exp_q.size() < MAX);
    if (c0 && c1) return 1 - model_last;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic model_check(input string t);
    int w;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_wr, e_rd, e_r0, e_r1;
    w = model_winner();
    e_addr = (w == 0) ? m0_addr : (w == 1) ? m1_addr : 32'h0;
    e_wd   = (w == 0) ? m0_write_data : (w == 1) ? m1_write_data : 32'h0;
    e_be   = (w == 0) ? m0_byte_enable : (w == 1) ? m1_byte_enable : 4'h0;
    e_wr   = (w == 0) ? m0_write_req : (w == 1) ? m1_write_req : 1'b0;
    e_rd   = (w == 0) ? m0_read_req : (w == 1) ? m1_read_req : 1'b0;
    e_r0   = bus_read_data_valid && exp_q.size() > 0 && exp_q[0] == 0;
    e_r1   = bus_read_data_valid && exp_q.size() > 0 && exp_q[0] == 1;
    chk1 ({t, " m0_ready"}, m0_ready, (w == 0) && bus_ready);
    chk1 ({t, " m1_ready"}, m1_ready, (w == 1) && bus_ready);
    chk32({t, " bus_addr"}, bus_addr, e_addr);
    chk32({t, " bus_wdata"}, bus_write_data, e_wd);
    chk32({t, " bus_be"}, {28'h0, bus_byte_enable}, {28'h0, e_be});
    chk1 ({t, " bus_wr"}, bus_write_req, e_wr);
    chk1 ({t, " bus_rd"}, bus_read_req, e_rd);
    chk1 ({t, " m0_rvalid"}, m0_read_data_valid, e_r0);
    chk1 ({t, " m1_rvalid"}, m1_read_data_valid, e_r1);
    chk32({t, " m0_rdata"}, m0_read_data, bus_read_data);
    chk32({t, " m1_rdata"}, m1_read_data, bus_read_data);
    chk1 ({t, " resp_error"}, resp_error, model_rerr);
  endtask

  task automatic model_update();
    int w;
    w = model_winner();
    model_rerr = 1'b0;
    if (bus_read_data_valid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else model_rerr = 1'b1;
    end
    if (w >= 0 && bus_ready) begin
      model_last = w;
      if ((w == 0 && m0_read_req) || (w == 1 && m1_read_req)) exp_q.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000;
    m0_write_data = 32'h0;   m1_write_data = 32'h5;
    m0_byte_enable = 4'h0;   m1_byte_enable = 4'hF;
    m0_write_req = 1'b0; m0_read_req = 1'b0;
    m1_write_req = 1'b0; m1_read_req = 1'b0;
    bus_ready = 1'b1; bus_read_data = 32'h0; bus_read_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    model_last = 1;
    model_rerr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string t);
    @(negedge clk);
    model_check(t);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic m0_rd, m0_wr, m1_rd, m1_wr, rdy, rv;
    logic [31:0] rdata;
    logic m0_rdy, m1_rdy, b_rd, b_wr;
    logic [31:0] b_addr, b_wdata;
    logic m0_rv, m1_rv, rerr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    clear_inputs();
    //           m0r m0w m1r m1w rdy rv  rdata           m0y m1y brd bwr addr           wd     r0  r1  err
    vecs[0]  = '{L0, L0, L0, L0, L1, L0, 32'h0,          L0, L0, L0, L0, 32'h0,         32'h0, L0, L0, L0};
    vecs[1]  = '{L1, L0, L1, L0, L1, L0, 32'h0,          L1, L0, L1, L0, 32'h1000_0000, 32'h0, L0, L0, L0};
    vecs[2]  = '{L1, L0, L1, L0, L1, L1, 32'hAAAA_0000,  L0, L1, L1, L0, 32'h2000_0000, 32'h5, L1, L0, L0};
    vecs[3]  = '{L0, L0, L0, L0, L1, L1, 32'hBBBB_0000,  L0, L0, L0, L0, 32'h0,         32'h0, L0, L1, L0};
    vecs[4]  = '{L0, L0, L0, L0, L1, L1, 32'hDEAD_0000,  L0, L0, L0, L0, 32'h0,         32'h0, L0, L0, L0};
    vecs[5]  = '{L0, L0, L0, L0, L1, L0, 32'h0,          L0, L0, L0, L0, 32'h0,         32'h0, L0, L0, L1};
    vecs[6]  = '{L0, L0, L0, L0, L1, L0, 32'h0,          L0, L0, L0, L0, 32'h0,         32'h0, L0, L0, L0};
    vecs[7]  = '{L0, L0, L0, L1, L0, L0, 32'h0,          L0, L0, L0, L1, 32'h2000_0000, 32'h5, L0, L0, L0};
    vecs[8]  = '{L0, L0, L0, L1, L0, L0, 32'h0,          L0, L0, L0, L1, 32'h2000_0000, 32'h5, L0, L0, L0};
    vecs[9]  = '{L0, L0, L0, L1, L1, L0, 32'h0,          L0, L1, L0, L1, 32'h2000_0000, 32'h5, L0, L0, L0};
    vecs[10] = '{L1, L0, L1, L0, L1, L0, 32'h0,          L1, L0, L1, L0, 32'h1000_0000, 32'h0, L0, L0, L0};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      m0_read_req = vecs[i].m0_rd; m0_write_req = vecs[i].m0_wr;
      m1_read_req = vecs[i].m1_rd; m1_write_req = vecs[i].m1_wr;
      bus_ready = vecs[i].rdy; bus_read_data_valid = vecs[i].rv;
      bus_read_data = vecs[i].rdata;
      @(negedge clk);
      chk1 ($sformatf("v%0d m0_ready", i), m0_ready, vecs[i].m0_rdy);
      chk1 ($sformatf("v%0d m1_ready", i), m1_ready, vecs[i].m1_rdy);
      chk1 ($sformatf("v%0d bus_rd", i), bus_read_req, vecs[i].b_rd);
      chk1 ($sformatf("v%0d bus_wr", i), bus_write_req, vecs[i].b_wr);
      chk32($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].b_addr);
      chk32($sformatf("v%0d bus_wdata", i), bus_write_data, vecs[i].b_wdata);
      chk1 ($sformatf("v%0d m0_rvalid", i), m0_read_data_valid, vecs[i].m0_rv);
      chk1 ($sformatf("v%0d m1_rvalid", i), m1_read_data_valid, vecs[i].m1_rv);
      chk32($sformatf("v%0d m0_rdata", i), m0_read_data, vecs[i].rdata);
      chk1 ($sformatf("v%0d resp_error", i), resp_error, vecs[i].rerr);
      @(posedge clk);
      #1;
    end

    // ---- full tag FIFO: reads stall, writes still go, pop unblocks next cycle
    do_reset();
    m0_addr = 32'h3000_0000;
    m0_read_req = 1'b1;
    for (int i = 0; i < MAX; i++) begin
      probe("fill");
      chk1("fill m0_ready", m0_ready, 1'b1);
      tick();
    end
    m1_write_req = 1'b1;
    probe("full");
    chk1("full m0_ready", m0_ready, 1'b0);
    chk1("full m1_write_ready", m1_ready, 1'b1);
    tick();
    m1_write_req = 1'b0;
    bus_read_data_valid = 1'b1;
    bus_read_data = 32'h1234_5678;
    probe("pop");
    chk1("pop same-cycle m0_ready", m0_ready, 1'b0);
    chk1("pop m0_rvalid", m0_read_data_valid, 1'b1);
    tick();
    bus_read_data_valid = 1'b0;
    probe("unblock");
    chk1("unblock m0_ready", m0_ready, 1'b1);
    tick();
    m0_read_req = 1'b0;

    // ---- reset with reads outstanding: stale response dropped and flagged
    do_reset();
    bus_read_data_valid = 1'b1;
    probe("stale");
    chk1("stale m0_rvalid", m0_read_data_valid, 1'b0);
    chk1("stale m1_rvalid", m1_read_data_valid, 1'b0);
    tick();
    bus_read_data_valid = 1'b0;
    m0_read_req = 1'b1;
    m1_read_req = 1'b1;
    probe("post-reset");
    chk1("stale resp_error pulse", resp_error, 1'b1);
    chk1("post-reset m0 wins", m0_ready, 1'b1);
    tick();
    probe("post-reset2");
    chk1("resp_error one cycle", resp_error, 1'b0);
    chk1("post-reset m1 next", m1_ready, 1'b1);
    tick();

    // ---- continuous contention with 1-cycle responses: strict alternation
    do_reset();
    m0_read_req = 1'b1;
    m1_read_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read_data_valid = (i > 0);
      bus_read_data = 32'h0000_0100 + i;
      probe("alt");
      chk1($sformatf("alt%0d m0_ready", i), m0_ready, (i % 2) == 0);
      tick();
    end
    clear_inputs();

    // ---- randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      m0_addr = $urandom; m1_addr = $urandom;
      m0_write_data = $urandom; m1_write_data = $urandom;
      m0_byte_enable = 4'($urandom_range(0, 15));
      m1_byte_enable = 4'($urandom_range(0, 15));
      m0_read_req  = ($urandom_range(0, 99) < 50);
      m0_write_req = ($urandom_range(0, 99) < 25);
      m1_read_req  = ($urandom_range(0, 99) < 50);
      m1_write_req = ($urandom_range(0, 99) < 25);
      bus_ready = ($urandom_range(0, 99) < 75);
      bus_read_data_valid = ($urandom_range(0, 99) < 40);
      bus_read_data = $urandom;
      if (c == 1000) begin
        do_reset();
      end else begin
        probe("rnd");
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
